// File: rtl/spu_regfile_wb.sv
// spu_regfile_wb: SPU register file fed by the even/odd writeback packets.
//   clk, reset            : clock, asynchronous active-low reset
//   wb_even, wb_odd       : writeback packets {data, unit tag, write enable, target}
//   addr_*_e / addr_*_o   : operand addresses for the even / odd dispatch stages
//   ra_e..rt_o            : registered operand data, one cycle after the address
//   busy                  : high while the post-reset clear sweep runs
//   wr_conflict           : one-cycle pulse when both pipes wrote the same register
//   wb_dropped            : sticky flag, a write-enabled packet arrived during the sweep
module spu_regfile_wb #(
   parameter int unsigned NUM_REGS = 128,
   parameter int unsigned DATA_W   = 128,
   parameter int unsigned PKT_W    = 139
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [0:PKT_W-1]  wb_even,
   input  logic [0:PKT_W-1]  wb_odd,
   input  logic [0:6]        addr_ra_e,
   input  logic [0:6]        addr_rb_e,
   input  logic [0:6]        addr_rc_e,
   input  logic [0:6]        addr_ra_o,
   input  logic [0:6]        addr_rb_o,
   input  logic [0:6]        addr_rt_o,
   output logic [0:DATA_W-1] ra_e,
   output logic [0:DATA_W-1] rb_e,
   output logic [0:DATA_W-1] rc_e,
   output logic [0:DATA_W-1] ra_o,
   output logic [0:DATA_W-1] rb_o,
   output logic [0:DATA_W-1] rt_o,
   output logic              busy,
   output logic              wr_conflict,
   output logic              wb_dropped
);

   localparam int unsigned AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned TAG_LO   = DATA_W;
   localparam int unsigned TAG_HI   = DATA_W + 2;
   localparam int unsigned WE_BIT   = DATA_W + 3;
   localparam int unsigned ADDR_LO  = DATA_W + 4;
   localparam int unsigned ADDR_HI  = DATA_W + 10;
   localparam int unsigned NUM_RD   = 6;

   typedef enum logic {CLEAR, READY} state_t;

   logic [DATA_W-1:0] mem [NUM_REGS];

   state_t            state, state_nxt;
   logic [AW-1:0]     clr_ptr, clr_ptr_nxt;

   logic [DATA_W-1:0] even_data, odd_data;
   logic              even_we, odd_we;
   logic [AW-1:0]     even_addr, odd_addr;
   logic [AW-1:0]     rd_addr [NUM_RD];

   logic              clr_we_c, even_wr_c, odd_wr_c, conflict_c, dropped_c;
   logic [DATA_W-1:0] rd_data_c [NUM_RD];

   // Unit tag is carried in the packet but has no meaning here
   logic unused_tag;
   assign unused_tag = ^{wb_even[TAG_LO:TAG_HI], wb_odd[TAG_LO:TAG_HI]};

   // Packet field extraction; data MSB is packet bit 0
   assign even_data = wb_even[0:DATA_W-1];
   assign odd_data  = wb_odd[0:DATA_W-1];
   assign even_we   = wb_even[WE_BIT];
   assign odd_we    = wb_odd[WE_BIT];
   assign even_addr = AW'(wb_even[ADDR_LO:ADDR_HI]);
   assign odd_addr  = AW'(wb_odd[ADDR_LO:ADDR_HI]);

   assign rd_addr[0] = AW'(addr_ra_e);
   assign rd_addr[1] = AW'(addr_rb_e);
   assign rd_addr[2] = AW'(addr_rc_e);
   assign rd_addr[3] = AW'(addr_ra_o);
   assign rd_addr[4] = AW'(addr_rb_o);
   assign rd_addr[5] = AW'(addr_rt_o);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
      end
   end

   // Next state: sweep every entry once, then stay READY until reset
   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      if (state == CLEAR) begin
         clr_ptr_nxt = clr_ptr + AW'(1);
         if (clr_ptr == AW'(NUM_REGS - 1)) begin
            state_nxt = READY;
         end
      end
   end

   // Write strobes and bypassed read data; odd pipe is younger so it wins
   always_comb begin
      clr_we_c   = (state == CLEAR);
      even_wr_c  = (state == READY) && even_we;
      odd_wr_c   = (state == READY) && odd_we;
      conflict_c = even_wr_c && odd_wr_c && (even_addr == odd_addr);
      dropped_c  = (state == CLEAR) && (even_we || odd_we);
      for (int i = 0; i < NUM_RD; i++) begin
         rd_data_c[i] = '0;
         if (state == READY) begin
            if (odd_wr_c && (odd_addr == rd_addr[i])) begin
               rd_data_c[i] = odd_data;
            end else if (even_wr_c && (even_addr == rd_addr[i])) begin
               rd_data_c[i] = even_data;
            end else begin
               rd_data_c[i] = mem[rd_addr[i]];
            end
         end
      end
   end

   // Array update; the sweep only advances once reset is released
   always_ff @(posedge clk) begin
      if (clr_we_c) begin
         if (reset) begin
            mem[clr_ptr] <= '0;
         end
      end else begin
         if (even_wr_c) begin
            mem[even_addr] <= even_data;
         end
         if (odd_wr_c) begin
            mem[odd_addr] <= odd_data;
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ra_e        <= '0;
         rb_e        <= '0;
         rc_e        <= '0;
         ra_o        <= '0;
         rb_o        <= '0;
         rt_o        <= '0;
         busy        <= 1'b1;
         wr_conflict <= 1'b0;
         wb_dropped  <= 1'b0;
      end else begin
         ra_e        <= rd_data_c[0];
         rb_e        <= rd_data_c[1];
         rc_e        <= rd_data_c[2];
         ra_o        <= rd_data_c[3];
         rb_o        <= rd_data_c[4];
         rt_o        <= rd_data_c[5];
         busy        <= (state_nxt == CLEAR);
         wr_conflict <= conflict_c;
         if (dropped_c) begin
            wb_dropped <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spu_regfile_wb.sv
// tb_spu_regfile_wb: randomized bench for spu_regfile_wb against an array model.
module tb_spu_regfile_wb;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [0:138] wb_even, wb_odd;
   logic [0:6]   addr_ra_e, addr_rb_e, addr_rc_e, addr_ra_o, addr_rb_o, addr_rt_o;
   logic [0:127] ra_e, rb_e, rc_e, ra_o, rb_o, rt_o;
   logic         busy, wr_conflict, wb_dropped;

   spu_regfile_wb dut (
      .clk(clk), .reset(reset),
      .wb_even(wb_even), .wb_odd(wb_odd),
      .addr_ra_e(addr_ra_e), .addr_rb_e(addr_rb_e), .addr_rc_e(addr_rc_e),
      .addr_ra_o(addr_ra_o), .addr_rb_o(addr_rb_o), .addr_rt_o(addr_rt_o),
      .ra_e(ra_e), .rb_e(rb_e), .rc_e(rc_e),
      .ra_o(ra_o), .rb_o(rb_o), .rt_o(rt_o),
      .busy(busy), .wr_conflict(wr_conflict), .wb_dropped(wb_dropped)
   );

   always #5 clk = ~clk;

   // Reference model: register contents, edges since reset, sticky drop flag
   logic [127:0] mem_m [128];
   int           sweep_cnt;
   logic         drop_m;
   int           n_checks = 0;
   int           n_pass = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [0:138] mkpkt(input logic we, input int a, input logic [127:0] d);
      logic [0:138] p;
      p[0:127]   = d;
      p[128:130] = 3'($urandom);
      p[131]     = we;
      p[132:138] = 7'(a);
      return p;
   endfunction

   task automatic set_addrs(input int a);
      addr_ra_e = 7'(a); addr_rb_e = 7'(a); addr_rc_e = 7'(a);
      addr_ra_o = 7'(a); addr_rb_o = 7'(a); addr_rt_o = 7'(a);
   endtask

   task automatic idle_pkts();
      wb_even = mkpkt(1'b0, $urandom_range(0, 127), rand128());
      wb_odd  = mkpkt(1'b0, $urandom_range(0, 127), rand128());
   endtask

   // One clock edge: predict from the applied inputs, then compare after the edge
   task automatic step();
      logic [127:0] exp [6];
      logic         exp_conf;
      logic         we_e, we_o;
      int           ae, ao;
      int           ad [6];
      we_e = wb_even[131]; ae = int'(wb_even[132:138]);
      we_o = wb_odd[131];  ao = int'(wb_odd[132:138]);
      ad[0] = int'(addr_ra_e); ad[1] = int'(addr_rb_e); ad[2] = int'(addr_rc_e);
      ad[3] = int'(addr_ra_o); ad[4] = int'(addr_rb_o); ad[5] = int'(addr_rt_o);
      exp_conf = 1'b0;
      if (sweep_cnt < 128) begin
         if (we_e || we_o) drop_m = 1'b1;
         mem_m[sweep_cnt] = '0;
         sweep_cnt++;
         for (int i = 0; i < 6; i++) exp[i] = '0;
      end else begin
         // Later write overwrites the earlier one; reads see the post-write array
         if (we_e) mem_m[ae] = wb_even[0:127];
         if (we_o) mem_m[ao] = wb_odd[0:127];
         exp_conf = we_e && we_o && (ae == ao);
         for (int i = 0; i < 6; i++) exp[i] = mem_m[ad[i]];
      end
      @(posedge clk);
      #1;
      check("ra_e", ra_e, exp[0]);
      check("rb_e", rb_e, exp[1]);
      check("rc_e", rc_e, exp[2]);
      check("ra_o", ra_o, exp[3]);
      check("rb_o", rb_o, exp[4]);
      check("rt_o", rt_o, exp[5]);
      check("busy", 128'(busy), 128'(sweep_cnt < 128));
      check("wr_conflict", 128'(wr_conflict), 128'(exp_conf));
      check("wb_dropped", 128'(wb_dropped), 128'(drop_m));
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic do_reset();
      reset = 1'b0;
      #1;
      sweep_cnt = 0;
      drop_m    = 1'b0;
      check("rst_busy", 128'(busy), 128'(1));
      check("rst_ra_e", ra_e, '0);
      check("rst_rt_o", rt_o, '0);
      check("rst_conflict", 128'(wr_conflict), '0);
      check("rst_dropped", 128'(wb_dropped), '0);
      #1;
      reset = 1'b1;
   endtask

   task automatic run_sweep(input bool_drop);
      for (int c = 0; c < 128; c++) begin
         set_addrs($urandom_range(0, 127));
         idle_pkts();
         if (bool_drop && c == 10) wb_even = mkpkt(1'b1, 33, rand128());
         step();
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem_m[i] = '0;
      sweep_cnt = 0;
      drop_m    = 1'b0;
      set_addrs(0);
      idle_pkts();
      #1;
      do_reset();

      // First sweep with a write-enabled packet at sweep cycle 10
      run_sweep(1'b1);
      check("busy_low_after_sweep", 128'(busy), '0);

      // Every register reads zero after the sweep
      idle_pkts();
      for (int i = 0; i < 128; i++) begin
         set_addrs($urandom_range(0, 127));
         addr_rt_o = 7'(i);
         step();
      end

      // Odd write to reg 5, then read it on the even port
      wb_odd = mkpkt(1'b1, 5, {16{8'hA5}});
      step();
      idle_pkts();
      addr_ra_e = 7'd5;
      step();

      // Same-target collision with bypass on rb_o
      wb_even = mkpkt(1'b1, 9, 128'd1);
      wb_odd  = mkpkt(1'b1, 9, 128'd2);
      addr_rb_o = 7'd9;
      step();
      idle_pkts();
      step();
      set_addrs(9);
      step();

      // Disabled packet has no effect
      wb_odd = mkpkt(1'b0, 3, 128'd7);
      wb_even = mkpkt(1'b0, 3, 128'd7);
      set_addrs(3);
      step();
      idle_pkts();
      step();

      // Randomized traffic over a narrow address range to force collisions
      for (int n = 0; n < 1500; n++) begin
         wb_even = mkpkt(1'($urandom_range(0, 1)), $urandom_range(0, 7), rand128());
         wb_odd  = mkpkt(1'($urandom_range(0, 1)), $urandom_range(0, 7), rand128());
         addr_ra_e = 7'($urandom_range(0, 7)); addr_rb_e = 7'($urandom_range(0, 7));
         addr_rc_e = 7'($urandom_range(0, 7)); addr_ra_o = 7'($urandom_range(0, 7));
         addr_rb_o = 7'($urandom_range(0, 7)); addr_rt_o = 7'($urandom_range(0, 127));
         step();
      end

      // Reg 20 written, reset, then reset again mid-sweep at cycle 50
      wb_even = mkpkt(1'b1, 20, 128'hFF);
      wb_odd  = mkpkt(1'b0, 0, rand128());
      set_addrs(20);
      step();
      idle_pkts();
      step();
      do_reset();
      for (int c = 0; c < 50; c++) begin
         idle_pkts();
         set_addrs(20);
         step();
      end
      do_reset();
      run_sweep(1'b0);
      check("busy_low_after_resweep", 128'(busy), '0);
      idle_pkts();
      set_addrs(20);
      step();
      check("reg20_cleared", rt_o, '0);

      // Short random tail after the re-sweep
      for (int n = 0; n < 300; n++) begin
         wb_even = mkpkt(1'($urandom_range(0, 1)), $urandom_range(16, 23), rand128());
         wb_odd  = mkpkt(1'($urandom_range(0, 1)), $urandom_range(16, 23), rand128());
         set_addrs($urandom_range(16, 23));
         addr_rc_e = 7'($urandom_range(0, 127));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spu_regfile_wb.md
Name: spu_regfile_wb

Overview:
- 128-entry x 128-bit SPU register file that consumes the final writeback packets of the even and odd pipes, including the load/store unit's stage-6 forward packet.
- Supplies operands to the even and odd dispatch stages through six registered read ports.
- Performs an explicit post-reset clear sweep and resolves dual-pipe write collisions.
- Provides write-through bypass, so an operand read in the same cycle as its writeback returns the new value.

Parameters:
- NUM_REGS, 128, register count; must be a power of two, max 128.
- DATA_W, 128, register width in bits.
- PKT_W, 139, writeback packet width: DATA_W + 3-bit unit tag + 1-bit write-enable + 7-bit target address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_even  in  [0:138]  even-pipe writeback packet.
- wb_odd  in  [0:138]  odd-pipe writeback packet; the load/store FWpipe6 output connects here.
- addr_ra_e, addr_rb_e, addr_rc_e  in  [0:6] each  even-pipe operand addresses.
- addr_ra_o, addr_rb_o, addr_rt_o  in  [0:6] each  odd-pipe operand addresses.
- ra_e, rb_e, rc_e, ra_o, rb_o, rt_o  out  [0:127] each  registered operand data.
- busy  out  1  high while the clear sweep runs.
- wr_conflict  out  1  one-cycle pulse: both pipes wrote the same register.
- wb_dropped  out  1  sticky: a write-enabled packet arrived while busy.

Behaviour:
- Packet fields (big-endian bit numbering):
  - [0:127] data.
  - [128:130] unit tag; ignored here.
  - [131] write enable.
  - [132:138] target register.
- Reset asserted (reset==0), effective immediately regardless of clk:
  - state=CLEAR, clr_ptr=0, busy=1.
  - All six read outputs=0; wr_conflict=0; wb_dropped=0.
  - Array contents are not reset asynchronously.
- State CLEAR:
  - On each rising edge after reset deassert, reg[clr_ptr]<=0 and clr_ptr increments.
  - The edge that writes entry NUM_REGS-1 moves the state to READY, and busy<=0 on that same edge.
  - busy is therefore high for exactly NUM_REGS edges after reset release.
  - Read outputs stay 0 throughout CLEAR.
  - Any packet with [131]=1 is discarded and sets wb_dropped<=1. wb_dropped clears only on reset.
- State READY writes:
  - If wb_even[131]=1: reg[wb_even[132:138]]<=wb_even[0:127].
  - If wb_odd[131]=1: reg[wb_odd[132:138]]<=wb_odd[0:127].
  - Both enabled with equal target: the odd packet wins (odd slot is later in program order), and wr_conflict<=1 for one cycle. Otherwise wr_conflict<=0.
  - A packet with [131]=0 has no effect, whatever its data.
- State READY reads:
  - Each output is registered: out<=value(addr) on the rising edge, giving 1-cycle latency.
  - value(addr) priority: odd write data if odd write-enabled to addr this cycle; else even write data if even write-enabled to addr; else array content.
  - Multiple ports may read the same address; all return identical data.
- Reset asserted mid-sweep or mid-operation: restarts the sweep from 0, and every register is cleared again.
- Addresses are 7 bits. If NUM_REGS<128, only the low log2(NUM_REGS) bits are used.
- The only state is CLEAR/READY; no other FSM states exist.

Test Plan:
- Release reset, hold all addresses at 0 -> busy high for 128 edges, then low; rt_o=0 for every register read 0..127 afterwards.
- After busy falls: wb_odd with [131]=1, target 5, data 128'hA5..A5; next cycle addr_ra_e=5 -> ra_e=A5..A5 one edge later.
- Same cycle: wb_even target 9 data 1, wb_odd target 9 data 2, addr_rb_o=9 -> rb_o=2 after that edge (bypass, odd priority), wr_conflict=1 for exactly one cycle; a later read of reg 9 returns 2.
- Packet target 3 data 7 with [131]=0 -> reg 3 still reads 0, wr_conflict stays 0.
- Write-enabled wb_even during CLEAR (cycle 10 of the sweep) -> wb_dropped=1 and held; its target reads 0 after the sweep.
- Write reg 20=0xFF, then assert reset at sweep cycle 50 of a second reset -> busy runs another full 128 edges; reg 20 reads 0.
